decode_stage: RTL

// - Pipelined successor to the single-cycle combinational decoder. Sits between fetch and execute.
// - Accepts one INSTR_W-bit instruction per valid/ready handshake. Presents the decoded control bundle

---
 rtl/isa_pkg.sv | 158 +++++++++++++++
 rtl/decode_comb.sv | 12 +
 rtl/decode_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ISA definitions for the 9-bit core: field encodings, control bundle layout and the
// combinational instruction decoder shared by the pipeline and the emulator checker.
package isa_pkg;

    localparam int unsigned INSTR_W  = 9;
    localparam int unsigned REG_W    = 8;
    localparam int unsigned NUM_REGS = 12;
    localparam int unsigned AW       = $clog2(NUM_REGS);
    localparam int unsigned OP_W     = 4;
    localparam int unsigned CTL_W    = 10;

    localparam logic [2:0] OpAlu  = 3'b000;
    localparam logic [2:0] OpMem  = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpAddi = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpTr   = 3'b101;
    localparam logic [2:0] OpJr   = 3'b110;
    localparam logic [2:0] OpShf  = 3'b111;

    localparam logic [1:0] SubLw   = 2'd0;
    localparam logic [1:0] SubSw   = 2'd1;
    localparam logic [1:0] SubInc  = 2'd2;
    localparam logic [1:0] SubLast = 2'd3;  // BEQ / NOT / DONE depending on opcode

    localparam logic [OP_W-1:0] AluNot  = 4'd3;
    localparam logic [OP_W-1:0] AluAdd  = 4'd4;
    localparam logic [OP_W-1:0] AluSub  = 4'd5;
    localparam logic [OP_W-1:0] AluPass = 4'd6;
    localparam logic [OP_W-1:0] AluBeq  = 4'd7;
    localparam logic [OP_W-1:0] AluSrl  = 4'd8;

    typedef struct packed {
        logic reg_write;
        logic car_write;
        logic sel_imm;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem2reg;
        logic done;
        logic rt_used;
    } ctl_t;

    typedef struct packed {
        logic [OP_W-1:0]  alu_op;
        logic [AW-1:0]    rs;
        logic [AW-1:0]    rt;
        logic [AW-1:0]    rd;
        logic [REG_W-1:0] imm;
        ctl_t             ctl;
    } dec_t;

    // Every field starts at zero so unused fields never carry X.
    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        dec_t          d;
        logic [AW-1:0] a, b, c, f4;
        d  = '0;
        a  = AW'(instr[5:4]);
        b  = AW'(instr[3:2]);
        c  = AW'(instr[1:0]);
        f4 = AW'(instr[5:2]);
        case (instr[8:6])
            OpAlu: begin
                d.ctl.rt_used = 1'b1;
                if (instr[1:0] == SubLast) begin
                    d.alu_op     = AluBeq;
                    d.rs         = a;
                    d.rt         = b + AW'(8);
                    d.ctl.branch = 1'b1;
                end else begin
                    d.alu_op        = OP_W'(instr[1:0]);
                    d.rs            = a + AW'(4);
                    d.rt            = b;
                    d.rd            = AW'(11);
                    d.ctl.reg_write = 1'b1;
                end
            end
            OpMem: begin
                case (instr[1:0])
                    SubLw: begin
                        d.alu_op        = AluPass;
                        d.rs            = b;
                        d.rd            = a + AW'(4);
                        d.ctl.reg_write = 1'b1;
                        d.ctl.mem_read  = 1'b1;
                        d.ctl.mem2reg   = 1'b1;
                    end
                    SubSw: begin
                        d.alu_op        = AluPass;
                        d.rs            = a + AW'(4);
                        d.rt            = b;
                        d.ctl.mem_write = 1'b1;
                        d.ctl.rt_used   = 1'b1;
                    end
                    SubInc: begin
                        d.alu_op        = AluAdd;
                        d.rs            = f4;
                        d.rd            = f4;
                        d.imm           = REG_W'(1);
                        d.ctl.sel_imm   = 1'b1;
                        d.ctl.reg_write = 1'b1;
                    end
                    default: begin
                        d.alu_op        = AluNot;
                        d.rs            = f4;
                        d.rd            = f4;
                        d.ctl.reg_write = 1'b1;
                    end
                endcase
            end
            OpAdd, OpSub: begin
                d.alu_op        = (instr[8:6] == OpAdd) ? AluAdd : AluSub;
                d.rs            = a + AW'(4);
                d.rt            = b;
                d.rd            = c + AW'(8);
                d.ctl.reg_write = 1'b1;
                d.ctl.car_write = 1'b1;
                d.ctl.rt_used   = 1'b1;
            end
            OpAddi: begin
                d.alu_op        = AluAdd;
                d.rs            = b;
                d.rd            = a + AW'(8);
                d.imm           = REG_W'(instr[1:0]);
                d.ctl.sel_imm   = 1'b1;
                d.ctl.reg_write = 1'b1;
            end
            OpTr: begin
                d.alu_op        = AluPass;
                d.rs            = AW'(instr[2:0]) + AW'(5);
                d.rd            = AW'(instr[5:3]) + AW'(1);
                d.ctl.reg_write = 1'b1;
            end
            OpJr: begin
                d.alu_op   = AluPass;
                d.imm      = {{(REG_W-6){instr[5]}}, instr[5:0]};
                d.ctl.jump = 1'b1;
            end
            default: begin
                if (instr[1:0] == SubLast) begin
                    d.ctl.done = 1'b1;
                end else begin
                    d.alu_op        = AluSrl + OP_W'(instr[1:0]);
                    d.rs            = a + AW'(4);
                    d.rt            = b;
                    d.rd            = a + AW'(4);
                    d.ctl.reg_write = 1'b1;
                    d.ctl.car_write = 1'b1;
                    d.ctl.rt_used   = 1'b1;
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder; thin wrapper so the same logic can be instanced
// by the pipeline stage and by the emulator checker.
module decode_comb
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output dec_t               o_dec
);

    assign o_dec = decode(i_instr);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake, load-use bubble
// insertion, flush on redirect, sticky halt after DONE retires and a saturating bubble counter.
module decode_stage
    import isa_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16,
    parameter bit          LU_STALL    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_alu_op,
    output logic [AW-1:0]          out_rs,
    output logic [AW-1:0]          out_rt,
    output logic [AW-1:0]          out_rd,
    output logic [REG_W-1:0]       out_imm,
    output logic [CTL_W-1:0]       out_ctl,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StRun, StHaltPend, StHalted} halt_state_e;

    dec_t                   w_dec;
    dec_t                   r_bundle;
    logic                   r_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    halt_state_e            r_state, w_state_d;
    logic                   w_hazard, w_in_ready, w_accept, w_out_fire;

    decode_comb u_decode_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // Younger instruction reads the register a load in the output register is about to write.
    assign w_hazard = LU_STALL && r_valid && r_bundle.ctl.mem_read && in_valid &&
                      ((w_dec.rs == r_bundle.rd) ||
                       (w_dec.ctl.rt_used && (w_dec.rt == r_bundle.rd)));

    assign w_in_ready = rst_n && !flush && (r_state == StRun) && !w_hazard &&
                        (!r_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_fire = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_hazard && out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Once DONE is accepted nothing younger may enter; a flush drops the unretired DONE.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StRun: begin
                if (w_accept && w_dec.ctl.done) begin
                    w_state_d = StHaltPend;
                end
            end
            StHaltPend: begin
                if (flush) begin
                    w_state_d = StRun;
                end else if (w_out_fire && r_bundle.ctl.done) begin
                    w_state_d = StHalted;
                end
            end
            StHalted: w_state_d = StHalted;
            default:  w_state_d = StRun;
        endcase
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign out_alu_op = r_bundle.alu_op;
    assign out_rs     = r_bundle.rs;
    assign out_rt     = r_bundle.rt;
    assign out_rd     = r_bundle.rd;
    assign out_imm    = r_bundle.imm;
    assign out_ctl    = r_bundle.ctl;
    assign halted     = (r_state == StHalted);
    assign stall_cnt  = r_stall_cnt;

endmodule
